dsp_preadd_mult_stage: RTL

//  Pre-adder / B1 / multiplier stage of the DSP48A1 slice. Sits directly downstream of the
//  A0/B0/D pipeline_mux input stages and consumes their outputs. Forms D+/-B (or passes B),

---
 rtl/dsp_preadd_mult_stage_if.sv | 26 ++
 rtl/dsp_preadd_mult_stage.sv | 92 +++++++++
 2 files changed

// File: rtl/dsp_preadd_mult_stage_if.sv
// rtl/dsp_preadd_mult_stage_if.sv - operand, control and result bundle for the pre-add/multiply stage
interface dsp_preadd_mult_stage_if #(
  parameter int WIDTH = 18
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   d;
  logic [1:0]         opmode_pre;
  logic               CEOPMODE;
  logic               CEB1;
  logic               CEM;
  logic               in_valid;
  logic [WIDTH-1:0]   b1_out;
  logic [2*WIDTH-1:0] m_out;
  logic               out_valid;

  modport master (
    output a, b, d, opmode_pre, CEOPMODE, CEB1, CEM, in_valid,
    input  b1_out, m_out, out_valid
  );

  modport slave (
    input  a, b, d, opmode_pre, CEOPMODE, CEB1, CEM, in_valid,
    output b1_out, m_out, out_valid
  );
endinterface

// File: rtl/dsp_preadd_mult_stage.sv
// rtl/dsp_preadd_mult_stage.sv - DSP48A1-style pre-adder, B1/A1 stage and multiplier with optional M register
module dsp_preadd_mult_stage #(
  parameter int WIDTH     = 18,
  parameter int B1REG     = 1,
  parameter int MREG      = 1,
  parameter int OPMODEREG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  dsp_preadd_mult_stage_if.slave   bus
);
  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_pre;
  logic [WIDTH-1:0]   w_a1;
  logic [WIDTH-1:0]   w_b1;
  logic               w_v1;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_m;
  logic               w_v2;

  generate
    if (OPMODEREG != 0) begin : g_opreg
      logic [1:0] r_opmode;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)              r_opmode <= '0;
        else if (bus.CEOPMODE) r_opmode <= bus.opmode_pre;
      end
      assign w_op = r_opmode;
    end else begin : g_opcomb
      assign w_op = bus.opmode_pre;
    end
  endgenerate

  // Carry/borrow out of the pre-adder is intentionally dropped (modulo 2^WIDTH).
  always_comb begin
    w_pre = bus.b;
    if (w_op[0]) w_pre = w_op[1] ? (bus.d - bus.b) : (bus.d + bus.b);
  end

  generate
    if (B1REG != 0) begin : g_b1reg
      logic [WIDTH-1:0] r_b1;
      logic [WIDTH-1:0] r_a1;
      logic             r_v1;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_b1 <= '0;
          r_a1 <= '0;
          r_v1 <= 1'b0;
        end else if (bus.CEB1) begin
          r_b1 <= w_pre;
          r_a1 <= bus.a;
          r_v1 <= bus.in_valid;
        end
      end
      assign w_b1 = r_b1;
      assign w_a1 = r_a1;
      assign w_v1 = r_v1;
    end else begin : g_b1comb
      assign w_b1 = w_pre;
      assign w_a1 = bus.a;
      assign w_v1 = bus.in_valid;
    end
  endgenerate

  assign w_prod = {{WIDTH{1'b0}}, w_a1} * {{WIDTH{1'b0}}, w_b1};

  generate
    if (MREG != 0) begin : g_mreg
      logic [2*WIDTH-1:0] r_m;
      logic               r_v2;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_m  <= '0;
          r_v2 <= 1'b0;
        end else if (bus.CEM) begin
          r_m  <= w_prod;
          r_v2 <= w_v1;
        end
      end
      assign w_m  = r_m;
      assign w_v2 = r_v2;
    end else begin : g_mcomb
      assign w_m  = w_prod;
      assign w_v2 = w_v1;
    end
  endgenerate

  assign bus.b1_out    = w_b1;
  assign bus.m_out     = w_m;
  assign bus.out_valid = w_v2;
endmodule
